uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- UART receiver; the receive-side counterpart of the team's UART transmitter.
- Frame format: 1 start bit (0), DATA_LEN data bits LSB first, 1 parity bit, 1 stop bit (1); idle line is 1.
- Oversamples the asynchronous serial line using a tick from the shared baud generator.
- Delivers each received word with a 1-clk valid pulse plus parity and framing status.

Parameters:
- DATA_LEN, 8, number of data bits per frame (>=5).
- PARITY_TYPE, 1, 1: expected parity bit = XOR of data bits (even); 0: XNOR (odd).
- OVERSAMPLE, 16, baud_tick_rx ticks per bit period; must be even and >=8.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- baud_tick_rx  input  1  1-clk enable pulse at OVERSAMPLE x baud rate.
- rx_in  input  1  asynchronous serial line.
- rx_data  output  DATA_LEN  last received word.
- rx_valid  output  1  1-clk pulse: rx_data, parity_err and frame_err are updated.
- parity_err  output  1  received parity bit did not match expected parity.
- frame_err  output  1  stop bit sampled as 0.
- rx_busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset is asynchronous, active-high, on clock clk.
- Reset values:
  - rx_data=0, rx_valid=0, parity_err=0, frame_err=0, rx_busy=0.
  - Synchronizer flops=1, state=IDLE, armed=1, all counters 0.
- Synchronizer: rx_in passes through a 2-flop synchronizer (rx_s). All sampling uses rx_s.
- Timing: all FSM and counter activity advances only on clk edges where baud_tick_rx=1. rx_valid is the only output that changes without a tick.
- Counters: tick_cnt is clog2(OVERSAMPLE) bits; bit_cnt is clog2(DATA_LEN+1) bits.
- IDLE:
  - If armed=0 and rx_s=1 on a tick, set armed=1.
  - If armed=1 and rx_s=0 on a tick, go to START with tick_cnt=0.
- START:
  - tick_cnt increments each tick.
  - Sample at tick_cnt==OVERSAMPLE/2-1 (mid start bit).
  - Sample=1: false start; return to IDLE with no output.
  - Sample=0: go to DATA with tick_cnt=0 and bit_cnt=0.
- DATA:
  - Sample at tick_cnt==OVERSAMPLE-1 (mid-bit); tick_cnt then wraps to 0.
  - Shift right, new bit entering the MSB: shreg <= {sample, shreg[DATA_LEN-1:1]}. Increment bit_cnt.
  - After the DATA_LEN-th sample, go to PARITY.
- PARITY:
  - Sample at tick_cnt==OVERSAMPLE-1.
  - perr = sample != (PARITY_TYPE ? ^shreg : ~^shreg). Go to STOP.
- STOP:
  - Sample at tick_cnt==OVERSAMPLE-1.
  - On that tick: rx_data<=shreg, parity_err<=perr, frame_err<=~sample, rx_valid<=1 (next clk cleared).
  - Go to IDLE. If sample=0, set armed=0.
- Latency: rx_valid is high on the clk following the stop-bit mid-sample tick.
- Output hold: rx_data, parity_err and frame_err are held until the next rx_valid. No backpressure; a new frame overwrites them.
- Framing error: data is still delivered with frame_err=1. A line held low (break) yields exactly one frame; no further frames start until rx_s has been seen high for one tick (armed).
- Back-to-back frames: a start bit immediately following the stop bit must be detected. IDLE is entered at the stop mid-sample, which leaves half a bit of margin.
- Reset mid-frame: returns immediately to reset values. The partial frame is discarded with no rx_valid.
- Tick input: baud_tick_rx high for multiple consecutive clks is legal; each such clk counts as a tick.

Optional Feature:
- Macro: UART_RX_MAJORITY_VOTE_EN.
- Defined:
  - Each bit value is the 2-of-3 majority of rx_s taken at the ticks where tick_cnt equals P-2, P-1 and P.
  - P is the single-sample point: OVERSAMPLE/2-1 for START, OVERSAMPLE-1 for the other states.
  - The decision is made at P.
  - A single-tick glitch at any one sample point does not alter the received bit.
- Undefined: a single sample at P; no vote registers are present.

Test Plan (DATA_LEN=8, PARITY_TYPE=1, OVERSAMPLE=16, 16 ticks per bit):
- Clean frame: drive start, 0xA5 LSB first (1,0,1,0,0,1,0,1), parity 0, stop 1 -> one rx_valid pulse; rx_data=0xA5, parity_err=0, frame_err=0; rx_busy low after stop.
- Parity error: drive 0x3C with parity bit 1 -> rx_valid, rx_data=0x3C, parity_err=1, frame_err=0.
- Glitch: drive rx_in low for 4 ticks then high -> no rx_valid; FSM back in IDLE; a following valid frame 0x5A is received correctly.
- Framing/break: drive 0x81, parity 0, stop 0, then hold low 3 bit-times -> exactly one rx_valid with rx_data=0x81, frame_err=1. Release high, then send 0x42 -> rx_data=0x42, frame_err=0.
- Back-to-back: send 0x00, 0xFF, 0x55 with no idle gap -> three rx_valid pulses with the correct data; parity_err=0 for all three.
- Reset mid-frame: assert rst during data bit 4 of 0x99 -> all outputs return to reset values, no rx_valid; the next frame 0x66 is received correctly.

Source files
------------

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampling UART receiver: start, DATA_LEN data bits LSB first, parity, stop.
// Define UART_RX_MAJORITY_VOTE_EN for a 2-of-3 vote around each sample point.
module uart_rx #(
    parameter int DATA_LEN    = 8,
    parameter int PARITY_TYPE = 1,
    parameter int OVERSAMPLE  = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                baud_tick_rx,
    input  logic                rx_in,
    output logic [DATA_LEN-1:0] rx_data,
    output logic                rx_valid,
    output logic                parity_err,
    output logic                frame_err,
    output logic                rx_busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_LEN + 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    logic                meta_q, rx_s_q;
    logic [2:0]          state_q, state_d;
    logic                armed_q, armed_d;
    logic [TW-1:0]       tick_cnt_q, tick_cnt_d;
    logic [BW-1:0]       bit_cnt_q, bit_cnt_d;
    logic [DATA_LEN-1:0] shreg_q, shreg_d;
    logic                perr_q, perr_d;
    logic [DATA_LEN-1:0] rx_data_q, rx_data_d;
    logic                parity_err_q, parity_err_d;
    logic                frame_err_q, frame_err_d;
    logic                rx_valid_q, rx_valid_d;

    logic [TW-1:0] sample_pt;
    logic          at_pt;
    logic          bit_val;
    logic          exp_par;

    // The start bit is sampled half a bit in; every later bit a full bit period after that.
    assign sample_pt = (state_q == START) ? TW'(OVERSAMPLE / 2 - 1) : TW'(OVERSAMPLE - 1);
    assign at_pt     = (tick_cnt_q == sample_pt);
    assign exp_par   = (PARITY_TYPE != 0) ? ^shreg_q : ~^shreg_q;

`ifdef UART_RX_MAJORITY_VOTE_EN
    logic vote_a_q, vote_b_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vote_a_q <= 1'b1;
            vote_b_q <= 1'b1;
        end else if (baud_tick_rx) begin
            if (tick_cnt_q == sample_pt - TW'(2)) vote_a_q <= rx_s_q;
            if (tick_cnt_q == sample_pt - TW'(1)) vote_b_q <= rx_s_q;
        end
    end

    assign bit_val = (vote_a_q & vote_b_q) | (vote_a_q & rx_s_q) | (vote_b_q & rx_s_q);
`else
    assign bit_val = rx_s_q;
`endif

    always_comb begin
        state_d      = state_q;
        armed_d      = armed_q;
        tick_cnt_d   = tick_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shreg_d      = shreg_q;
        perr_d       = perr_q;
        rx_data_d    = rx_data_q;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;
        rx_valid_d   = 1'b0;
        if (baud_tick_rx) begin
            case (state_q)
                IDLE: begin
                    if (!armed_q) begin
                        if (rx_s_q) armed_d = 1'b1;
                    end else if (!rx_s_q) begin
                        state_d    = START;
                        tick_cnt_d = '0;
                    end
                end
                START: begin
                    if (at_pt) begin
                        tick_cnt_d = '0;
                        bit_cnt_d  = '0;
                        state_d    = bit_val ? IDLE : DATA;
                    end else begin
                        tick_cnt_d = tick_cnt_q + TW'(1);
                    end
                end
                DATA: begin
                    if (at_pt) begin
                        tick_cnt_d = '0;
                        shreg_d    = {bit_val, shreg_q[DATA_LEN-1:1]};
                        bit_cnt_d  = bit_cnt_q + BW'(1);
                        if (bit_cnt_q == BW'(DATA_LEN - 1)) state_d = PARITY;
                    end else begin
                        tick_cnt_d = tick_cnt_q + TW'(1);
                    end
                end
                PARITY: begin
                    if (at_pt) begin
                        tick_cnt_d = '0;
                        perr_d     = (bit_val != exp_par);
                        state_d    = STOP;
                    end else begin
                        tick_cnt_d = tick_cnt_q + TW'(1);
                    end
                end
                STOP: begin
                    if (at_pt) begin
                        tick_cnt_d   = '0;
                        rx_data_d    = shreg_q;
                        parity_err_d = perr_q;
                        frame_err_d  = ~bit_val;
                        rx_valid_d   = 1'b1;
                        // A low stop bit may be a break; wait for the line to return high.
                        armed_d      = bit_val;
                        state_d      = IDLE;
                    end else begin
                        tick_cnt_d = tick_cnt_q + TW'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q       <= 1'b1;
            rx_s_q       <= 1'b1;
            state_q      <= IDLE;
            armed_q      <= 1'b1;
            tick_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            shreg_q      <= '0;
            perr_q       <= 1'b0;
            rx_data_q    <= '0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            rx_valid_q   <= 1'b0;
        end else begin
            meta_q       <= rx_in;
            rx_s_q       <= meta_q;
            state_q      <= state_d;
            armed_q      <= armed_d;
            tick_cnt_q   <= tick_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shreg_q      <= shreg_d;
            perr_q       <= perr_d;
            rx_data_q    <= rx_data_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            rx_valid_q   <= rx_valid_d;
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign rx_busy    = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed self-checking bench for uart_rx (8 data bits, even parity, 16x).
module tb_uart_rx;

    logic       clk;
    logic       rst;
    logic       baud_tick_rx;
    logic       rx_in;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       parity_err;
    logic       frame_err;
    logic       rx_busy;

    int vectors     = 0;
    int miscompares = 0;
    int tdiv        = 0;

    logic [7:0] q_data[$];
    logic       q_perr[$];
    logic       q_ferr[$];

    uart_rx #(.DATA_LEN(8), .PARITY_TYPE(1), .OVERSAMPLE(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .baud_tick_rx(baud_tick_rx),
        .rx_in       (rx_in),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .parity_err  (parity_err),
        .frame_err   (frame_err),
        .rx_busy     (rx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One tick every 4 clocks: 16 ticks = 64 clocks per bit.
    initial begin
        baud_tick_rx = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            tdiv = (tdiv + 1) % 4;
            baud_tick_rx = (tdiv == 0);
        end
    end

    always @(negedge clk) begin
        if (rx_valid === 1'b1) begin
            q_data.push_back(rx_data);
            q_perr.push_back(parity_err);
            q_ferr.push_back(frame_err);
        end
    end

    task automatic clear_q();
        q_data.delete();
        q_perr.delete();
        q_ferr.delete();
    endtask

    task automatic send_bit(input logic b);
        rx_in = b;
        repeat (64) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stp);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(par);
        send_bit(stp);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rx_in = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        vectors++; if (rx_data !== 8'h00) begin miscompares++; $display("FAIL reset_rx_data got %h exp 00", rx_data); end
        vectors++; if (rx_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rx_valid got %b exp 0", rx_valid); end
        vectors++; if (parity_err !== 1'b0) begin miscompares++; $display("FAIL reset_parity_err got %b exp 0", parity_err); end
        vectors++; if (frame_err !== 1'b0) begin miscompares++; $display("FAIL reset_frame_err got %b exp 0", frame_err); end
        vectors++; if (rx_busy !== 1'b0) begin miscompares++; $display("FAIL reset_rx_busy got %b exp 0", rx_busy); end
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (64) @(posedge clk);
        #1;
    endtask

    task automatic test_clean();
        clear_q();
        send_frame(8'hA5, 1'b0, 1'b1);
        send_bit(1'b1);
        vectors++; if (q_data.size() !== 1) begin miscompares++; $display("FAIL clean_count got %0d exp 1", q_data.size()); end
        if (q_data.size() > 0) begin
            vectors++; if (q_data[0] !== 8'hA5) begin miscompares++; $display("FAIL clean_data got %h exp a5", q_data[0]); end
            vectors++; if (q_perr[0] !== 1'b0) begin miscompares++; $display("FAIL clean_perr got %b exp 0", q_perr[0]); end
            vectors++; if (q_ferr[0] !== 1'b0) begin miscompares++; $display("FAIL clean_ferr got %b exp 0", q_ferr[0]); end
        end
        vectors++; if (rx_busy !== 1'b0) begin miscompares++; $display("FAIL clean_busy got %b exp 0", rx_busy); end
        vectors++; if (rx_data !== 8'hA5) begin miscompares++; $display("FAIL clean_hold got %h exp a5", rx_data); end
    endtask

    task automatic test_parity();
        clear_q();
        send_frame(8'h3C, 1'b1, 1'b1);
        send_bit(1'b1);
        vectors++; if (q_data.size() !== 1) begin miscompares++; $display("FAIL parity_count got %0d exp 1", q_data.size()); end
        if (q_data.size() > 0) begin
            vectors++; if (q_data[0] !== 8'h3C) begin miscompares++; $display("FAIL parity_data got %h exp 3c", q_data[0]); end
            vectors++; if (q_perr[0] !== 1'b1) begin miscompares++; $display("FAIL parity_perr got %b exp 1", q_perr[0]); end
            vectors++; if (q_ferr[0] !== 1'b0) begin miscompares++; $display("FAIL parity_ferr got %b exp 0", q_ferr[0]); end
        end
    endtask

    task automatic test_glitch();
        clear_q();
        rx_in = 1'b0;
        repeat (16) @(posedge clk);
        #1;
        rx_in = 1'b1;
        repeat (128) @(posedge clk);
        #1;
        vectors++; if (q_data.size() !== 0) begin miscompares++; $display("FAIL glitch_count got %0d exp 0", q_data.size()); end
        vectors++; if (rx_busy !== 1'b0) begin miscompares++; $display("FAIL glitch_busy got %b exp 0", rx_busy); end
        send_frame(8'h5A, 1'b0, 1'b1);
        send_bit(1'b1);
        vectors++; if (q_data.size() !== 1) begin miscompares++; $display("FAIL glitch_next_count got %0d exp 1", q_data.size()); end
        if (q_data.size() > 0) begin
            vectors++; if (q_data[0] !== 8'h5A) begin miscompares++; $display("FAIL glitch_next_data got %h exp 5a", q_data[0]); end
            vectors++; if (q_perr[0] !== 1'b0) begin miscompares++; $display("FAIL glitch_next_perr got %b exp 0", q_perr[0]); end
        end
    endtask

    task automatic test_break();
        clear_q();
        send_frame(8'h81, 1'b0, 1'b0);
        rx_in = 1'b0;
        repeat (3 * 64) @(posedge clk);
        #1;
        vectors++; if (q_data.size() !== 1) begin miscompares++; $display("FAIL break_count got %0d exp 1", q_data.size()); end
        if (q_data.size() > 0) begin
            vectors++; if (q_data[0] !== 8'h81) begin miscompares++; $display("FAIL break_data got %h exp 81", q_data[0]); end
            vectors++; if (q_ferr[0] !== 1'b1) begin miscompares++; $display("FAIL break_ferr got %b exp 1", q_ferr[0]); end
        end
        vectors++; if (rx_busy !== 1'b0) begin miscompares++; $display("FAIL break_busy got %b exp 0", rx_busy); end
        clear_q();
        send_bit(1'b1);
        send_frame(8'h42, 1'b0, 1'b1);
        send_bit(1'b1);
        vectors++; if (q_data.size() !== 1) begin miscompares++; $display("FAIL break_next_count got %0d exp 1", q_data.size()); end
        if (q_data.size() > 0) begin
            vectors++; if (q_data[0] !== 8'h42) begin miscompares++; $display("FAIL break_next_data got %h exp 42", q_data[0]); end
            vectors++; if (q_ferr[0] !== 1'b0) begin miscompares++; $display("FAIL break_next_ferr got %b exp 0", q_ferr[0]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_d[3];
        exp_d[0] = 8'h00;
        exp_d[1] = 8'hFF;
        exp_d[2] = 8'h55;
        clear_q();
        send_frame(8'h00, 1'b0, 1'b1);
        send_frame(8'hFF, 1'b0, 1'b1);
        send_frame(8'h55, 1'b0, 1'b1);
        send_bit(1'b1);
        vectors++; if (q_data.size() !== 3) begin miscompares++; $display("FAIL b2b_count got %0d exp 3", q_data.size()); end
        for (int i = 0; i < 3; i++) begin
            if (q_data.size() > i) begin
                vectors++; if (q_data[i] !== exp_d[i]) begin miscompares++; $display("FAIL b2b_data%0d got %h exp %h", i, q_data[i], exp_d[i]); end
                vectors++; if (q_perr[i] !== 1'b0) begin miscompares++; $display("FAIL b2b_perr%0d got %b exp 0", i, q_perr[i]); end
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] d;
        d = 8'h99;
        clear_q();
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(d[i]);
        rx_in = d[4];
        repeat (32) @(posedge clk);
        #1;
        vectors++; if (rx_busy !== 1'b1) begin miscompares++; $display("FAIL mid_busy_before got %b exp 1", rx_busy); end
        rst = 1'b1;
        #2;
        vectors++; if (rx_data !== 8'h00) begin miscompares++; $display("FAIL mid_rx_data got %h exp 00", rx_data); end
        vectors++; if (rx_valid !== 1'b0) begin miscompares++; $display("FAIL mid_rx_valid got %b exp 0", rx_valid); end
        vectors++; if (parity_err !== 1'b0) begin miscompares++; $display("FAIL mid_parity_err got %b exp 0", parity_err); end
        vectors++; if (frame_err !== 1'b0) begin miscompares++; $display("FAIL mid_frame_err got %b exp 0", frame_err); end
        vectors++; if (rx_busy !== 1'b0) begin miscompares++; $display("FAIL mid_rx_busy got %b exp 0", rx_busy); end
        rx_in = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (128) @(posedge clk);
        #1;
        vectors++; if (q_data.size() !== 0) begin miscompares++; $display("FAIL mid_count got %0d exp 0", q_data.size()); end
        send_frame(8'h66, 1'b0, 1'b1);
        send_bit(1'b1);
        vectors++; if (q_data.size() !== 1) begin miscompares++; $display("FAIL mid_next_count got %0d exp 1", q_data.size()); end
        if (q_data.size() > 0) begin
            vectors++; if (q_data[0] !== 8'h66) begin miscompares++; $display("FAIL mid_next_data got %h exp 66", q_data[0]); end
            vectors++; if (q_perr[0] !== 1'b0) begin miscompares++; $display("FAIL mid_next_perr got %b exp 0", q_perr[0]); end
        end
    endtask

    initial begin
        rst = 1'b1;
        rx_in = 1'b1;
        test_reset();
        test_clean();
        test_parity();
        test_glitch();
        test_break();
        test_back_to_back();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
